// File: rtl/change_dispenser_if.sv
// Change-request handshake between a requester and the dispenser.
interface change_dispenser_if;
  logic       req_valid;
  logic [7:0] req_amount;
  logic       req_ready;

  modport master (output req_valid, req_amount, input req_ready);
  modport slave  (input req_valid, req_amount, output req_ready);
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin dispenser: pays out a requested amount one coin at a time,
// largest available denomination first, with timed eject pulses.
module change_dispenser #(
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int INV_INIT  = 8
) (
  input  logic                clk,
  input  logic                rst,
  change_dispenser_if.slave   req,
  input  logic                abort,
  input  logic                refill,
  output logic [4:0]          coin_pulse,
  output logic                busy,
  output logic                done,
  output logic                short,
  output logic [7:0]          remaining,
  output logic [4:0]          coin_empty
);

  localparam int NUM_DEN = 5;
  localparam logic [NUM_DEN-1:0][7:0] DENOM = {8'd50, 8'd20, 8'd10, 8'd5, 8'd1};
  localparam logic [7:0] PCYC = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GCYC = 8'(GAP_CYC - 1);
  localparam logic [7:0] INV8 = 8'(INV_INIT);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, FINISH} state_t;

  state_t                    state;
  logic [NUM_DEN-1:0][7:0]   inv;
  logic [7:0]                cnt;
  logic [NUM_DEN-1:0]        cand, pick;
  logic [7:0]                sel_amt;
  logic                      hs;

  assign req.req_ready = (state == IDLE);
  assign hs            = req.req_valid && (state == IDLE);

  for (genvar i = 0; i < NUM_DEN; i++) begin : g_den
    assign cand[i]       = (DENOM[i] <= remaining) && (inv[i] != 8'd0);
    assign coin_empty[i] = (inv[i] == 8'd0);
  end

  // Highest-value eligible denomination wins.
  always_comb begin
    pick    = '0;
    sel_amt = '0;
    for (int k = NUM_DEN-1; k >= 0; k--)
      if (cand[k] && pick == '0) begin
        pick[k] = 1'b1;
        sel_amt = DENOM[k];
      end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      inv        <= {NUM_DEN{INV8}};
      cnt        <= '0;
      remaining  <= '0;
      coin_pulse <= '0;
      done       <= 1'b0;
      short      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done  <= 1'b0;
      short <= 1'b0;
      case (state)
        IDLE: begin
          if (refill) inv <= {NUM_DEN{INV8}};
          if (hs) begin
            remaining <= req.req_amount;
            busy      <= 1'b1;
            if (req.req_amount == 8'd0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= SELECT;
            end
          end
        end
        SELECT: begin
          if (abort || pick == '0) begin
            state <= FINISH;
            done  <= 1'b1;
            short <= (remaining != 8'd0);
          end else begin
            for (int k = 0; k < NUM_DEN; k++)
              if (pick[k]) inv[k] <= inv[k] - 8'd1;
            remaining  <= remaining - sel_amt;
            coin_pulse <= pick;
            cnt        <= PCYC;
            state      <= PULSE;
          end
        end
        PULSE: begin
          if (abort) begin
            coin_pulse <= '0;
            state      <= FINISH;
            done       <= 1'b1;
            short      <= (remaining != 8'd0);
          end else if (cnt == 8'd0) begin
            coin_pulse <= '0;
            cnt        <= GCYC;
            state      <= GAP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (abort || (cnt == 8'd0 && remaining == 8'd0)) begin
            state <= FINISH;
            done  <= 1'b1;
            short <= (remaining != 8'd0);
          end else if (cnt == 8'd0) begin
            state <= SELECT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
